traffic_light_fsm: RTL and testbench

Phase sequencer for the two-road traffic light. It consumes the three 7-bit phase durations held by the timing register bank: main green, secondary green and yellow, in seconds. It drives the red/yellow/green lamps of the main and secondary roads through a fixed four-phase cycle. A one-second enable pulse paces the sequencer, and it exposes the remaining time of the current phase for the display path.

---
 rtl/traffic_light_fsm_pkg.sv | 49 ++++
 rtl/traffic_light_fsm_phase_timer.sv | 45 ++++
 rtl/traffic_light_fsm.sv | 103 ++++++++++
 tb/tb_traffic_light_fsm.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/traffic_light_fsm_pkg.sv
// Shared types and constants for the two-road traffic light sequencer.
package traffic_light_fsm_pkg;

  localparam int unsigned DUR_W  = 7;
  localparam int unsigned LAMP_W = 3;

  typedef enum logic [2:0] {
    ST_INIT        = 3'd0,
    ST_MAIN_GREEN  = 3'd1,
    ST_MAIN_YELLOW = 3'd2,
    ST_SEC_GREEN   = 3'd3,
    ST_SEC_YELLOW  = 3'd4
  } state_e;

  // Lamp encoding is {red, yellow, green}
  localparam logic [LAMP_W-1:0] RED    = 3'b100;
  localparam logic [LAMP_W-1:0] YELLOW = 3'b010;
  localparam logic [LAMP_W-1:0] GREEN  = 3'b001;

  typedef struct packed {
    logic [LAMP_W-1:0] main_lamp;
    logic [LAMP_W-1:0] sec_lamp;
  } lamps_t;

  function automatic lamps_t lamps_for(input state_e s);
    lamps_t l;
    l.main_lamp = RED;
    l.sec_lamp  = RED;
    case (s)
      ST_MAIN_GREEN:  l.main_lamp = GREEN;
      ST_MAIN_YELLOW: l.main_lamp = YELLOW;
      ST_SEC_GREEN:   l.sec_lamp  = GREEN;
      ST_SEC_YELLOW:  l.sec_lamp  = YELLOW;
      default: ;
    endcase
    return l;
  endfunction

  function automatic state_e next_phase(input state_e s);
    case (s)
      ST_MAIN_GREEN:  return ST_MAIN_YELLOW;
      ST_MAIN_YELLOW: return ST_SEC_GREEN;
      ST_SEC_GREEN:   return ST_SEC_YELLOW;
      ST_SEC_YELLOW:  return ST_MAIN_GREEN;
      default:        return ST_MAIN_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_fsm_phase_timer.sv
// Loadable down-counter holding the ticks left in the current phase.
module phase_timer
  import traffic_light_fsm_pkg::*;
#(
  parameter int unsigned MIN_TIME = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [DUR_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [DUR_W-1:0] remaining_o,
  output logic             term_c
);

  localparam logic [DUR_W-1:0] MIN_VAL = DUR_W'(MIN_TIME);

  logic [DUR_W-1:0] remaining_q;
  logic [DUR_W-1:0] remaining_d;
  logic [DUR_W-1:0] clamped_c;

  assign clamped_c = (load_val_i < MIN_VAL) ? MIN_VAL : load_val_i;

  // Decrement stops at 1; reaching the terminal count is the FSM's job
  always_comb begin
    remaining_d = remaining_q;
    if (load_i) begin
      remaining_d = clamped_c;
    end else if (en_i && (remaining_q > DUR_W'(1))) begin
      remaining_d = remaining_q - DUR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
    end else begin
      remaining_q <= remaining_d;
    end
  end

  assign remaining_o = remaining_q;
  assign term_c      = (remaining_q == DUR_W'(1));

endmodule

// File: rtl/traffic_light_fsm.sv
// Four-phase two-road traffic light sequencer paced by a one-second tick.
module traffic_light_fsm
  import traffic_light_fsm_pkg::*;
#(
  parameter int unsigned MIN_TIME = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              hold,
  input  logic [DUR_W-1:0]  TpvIn,
  input  logic [DUR_W-1:0]  TsvIn,
  input  logic [DUR_W-1:0]  TaIn,
  output logic [LAMP_W-1:0] mainLight,
  output logic [LAMP_W-1:0] secLight,
  output logic [DUR_W-1:0]  remaining,
  output logic              phaseDone
);

  state_e           state_q;
  state_e           state_d;
  lamps_t           lamps_q;
  lamps_t           lamps_d;
  logic             phase_done_q;
  logic             phase_done_d;
  logic             load_c;
  logic             dec_c;
  logic             term_c;
  logic             eff_tick_c;
  logic [DUR_W-1:0] load_val_c;

  assign eff_tick_c = tick & ~hold;

  // Next-state and timer control; INIT ignores tick and hold
  always_comb begin
    state_d      = state_q;
    phase_done_d = 1'b0;
    load_c       = 1'b0;
    dec_c        = 1'b0;
    case (state_q)
      ST_INIT: begin
        state_d      = ST_MAIN_GREEN;
        load_c       = 1'b1;
        phase_done_d = 1'b1;
      end
      ST_MAIN_GREEN, ST_MAIN_YELLOW, ST_SEC_GREEN, ST_SEC_YELLOW: begin
        if (eff_tick_c) begin
          if (term_c) begin
            state_d      = next_phase(state_q);
            load_c       = 1'b1;
            phase_done_d = 1'b1;
          end else begin
            dec_c = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Duration is chosen by the phase being entered
  always_comb begin
    load_val_c = TaIn;
    case (state_d)
      ST_MAIN_GREEN: load_val_c = TpvIn;
      ST_SEC_GREEN:  load_val_c = TsvIn;
      default:       load_val_c = TaIn;
    endcase
  end

  assign lamps_d = lamps_for(state_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      lamps_q      <= '{main_lamp: RED, sec_lamp: RED};
      phase_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lamps_q      <= lamps_d;
      phase_done_q <= phase_done_d;
    end
  end

  phase_timer #(
    .MIN_TIME (MIN_TIME)
  ) u_phase_timer (
    .clk         (clk),
    .rst_n       (reset),
    .load_i      (load_c),
    .load_val_i  (load_val_c),
    .en_i        (dec_c),
    .remaining_o (remaining),
    .term_c      (term_c)
  );

  assign mainLight = lamps_q.main_lamp;
  assign secLight  = lamps_q.sec_lamp;
  assign phaseDone = phase_done_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm: phase cycle, clamping, mid-phase
// duration change, hold, asynchronous reset and per-cycle lamp invariants.
module tb_traffic_light_fsm;
  import traffic_light_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       hold;
  logic [6:0] TpvIn;
  logic [6:0] TsvIn;
  logic [6:0] TaIn;
  logic [2:0] mainLight;
  logic [2:0] secLight;
  logic [6:0] remaining;
  logic       phaseDone;

  int checks   = 0;
  int failures = 0;
  int pd_cnt   = 0;

  always #5 clk = ~clk;

  traffic_light_fsm #(.MIN_TIME(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .hold      (hold),
    .TpvIn     (TpvIn),
    .TsvIn     (TsvIn),
    .TaIn      (TaIn),
    .mainLight (mainLight),
    .secLight  (secLight),
    .remaining (remaining),
    .phaseDone (phaseDone)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] m, input logic [2:0] s,
                            input logic [6:0] r);
    check({tag, "_main"}, 32'(mainLight), 32'(m));
    check({tag, "_sec"}, 32'(secLight), 32'(s));
    check({tag, "_rem"}, 32'(remaining), 32'(r));
  endtask

  // Advance to the next falling edge, then check the lamp invariants
  task automatic cyc();
    @(negedge clk);
    check("main_onehot", 32'($onehot(mainLight)), 32'd1);
    check("sec_onehot", 32'($onehot(secLight)), 32'd1);
    check("no_dual_green", 32'(mainLight == GREEN && secLight == GREEN), 32'd0);
    check("rem_ge1", 32'((remaining != 7'd0) || (mainLight == RED && secLight == RED)), 32'd1);
    if (phaseDone === 1'b1) pd_cnt++;
  endtask

  task automatic do_tick(input int gap);
    repeat (gap - 1) cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) do_tick(gap);
  endtask

  initial begin
    reset = 1'b0;
    tick  = 1'b0;
    hold  = 1'b0;
    TpvIn = 7'd30;
    TsvIn = 7'd15;
    TaIn  = 7'd3;

    repeat (3) cyc();
    expect_out("reset", RED, RED, 7'd0);
    check("reset_pd", 32'(phaseDone), 32'd0);

    reset  = 1'b1;
    pd_cnt = 0;
    #1 expect_out("init", RED, RED, 7'd0);
    cyc();
    expect_out("mg_entry", GREEN, RED, 7'd30);
    check("mg_entry_pd", 32'(phaseDone), 32'd1);
    cyc();
    check("mg_pd_clear", 32'(phaseDone), 32'd0);
    check("mg_hold_rem", 32'(remaining), 32'd30);

    // Full 51-tick cycle with a tick every 10 clocks
    ticks(29, 10);
    expect_out("mg_last", GREEN, RED, 7'd1);
    do_tick(10);
    expect_out("my_entry", YELLOW, RED, 7'd3);
    ticks(3, 10);
    expect_out("sg_entry", RED, GREEN, 7'd15);
    ticks(15, 10);
    expect_out("sy_entry", RED, YELLOW, 7'd3);
    ticks(3, 10);
    expect_out("mg_again", GREEN, RED, 7'd30);
    check("pd_count_cycle", 32'(pd_cnt), 32'd5);

    // Duration change mid-phase only affects the next entry
    ticks(5, 4);
    check("mg_rem25", 32'(remaining), 32'd25);
    TpvIn = 7'd10;
    ticks(24, 4);
    expect_out("mg_old_len", GREEN, RED, 7'd1);
    do_tick(4);
    expect_out("my_after_change", YELLOW, RED, 7'd3);
    ticks(21, 4);
    expect_out("mg_new_len", GREEN, RED, 7'd10);

    // Hold drops ticks
    ticks(5, 4);
    check("hold_pre", 32'(remaining), 32'd5);
    hold = 1'b1;
    ticks(2, 10);
    expect_out("hold", GREEN, RED, 7'd5);
    hold = 1'b0;
    do_tick(10);
    expect_out("hold_release", GREEN, RED, 7'd4);

    // Clamp of zero duration and maximum yellow
    TpvIn = 7'd0;
    TaIn  = 7'd127;
    ticks(4, 2);
    expect_out("my_127", YELLOW, RED, 7'd127);
    ticks(126, 2);
    expect_out("my_127_last", YELLOW, RED, 7'd1);
    do_tick(2);
    expect_out("sg_after_127", RED, GREEN, 7'd15);
    ticks(15, 2);
    expect_out("sy_127", RED, YELLOW, 7'd127);
    ticks(127, 2);
    expect_out("mg_clamped", GREEN, RED, 7'd1);
    do_tick(2);
    expect_out("mg_one_tick", YELLOW, RED, 7'd127);
    TaIn  = 7'd3;
    TpvIn = 7'd30;
    ticks(127, 2);
    expect_out("sg_before_rst", RED, GREEN, 7'd15);
    ticks(8, 2);
    expect_out("sg_rem7", RED, GREEN, 7'd7);

    // Asynchronous reset mid-phase, then recovery ignoring hold/tick in INIT
    #2 reset = 1'b0;
    #1 expect_out("async_rst", RED, RED, 7'd0);
    check("async_rst_pd", 32'(phaseDone), 32'd0);
    cyc();
    hold  = 1'b1;
    tick  = 1'b1;
    reset = 1'b1;
    pd_cnt = 0;
    #1 expect_out("reinit", RED, RED, 7'd0);
    cyc();
    expect_out("re_mg_entry", GREEN, RED, 7'd30);
    check("re_mg_pd", 32'(pd_cnt), 32'd1);
    hold = 1'b0;
    tick = 1'b0;
    cyc();
    check("re_mg_steady", 32'(remaining), 32'd30);
    do_tick(10);
    check("re_mg_first_tick", 32'(remaining), 32'd29);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
